// File: rtl/mips_debug_pkg.sv
// Shared constants and types for the MIPS debug controller.
package mips_debug_pkg;

  // Host command bytes (ASCII)
  localparam logic [7:0] CMD_RUN  = 8'h63;  // 'c'
  localparam logic [7:0] CMD_STEP = 8'h73;  // 's'
  localparam logic [7:0] CMD_HALT = 8'h68;  // 'h'
  localparam logic [7:0] CMD_DUMP = 8'h64;  // 'd'

  // Default core debug bus width and resulting frame layout
  localparam int DEBUG_W_DEF = 322;
  localparam int CNT_BYTES   = 4;
  localparam int SNAP_BYTES  = (DEBUG_W_DEF + 7) / 8;
  localparam int FRAME_BYTES = CNT_BYTES + SNAP_BYTES;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_STEP,
    ST_CAPTURE,
    ST_SEND
  } state_t;

endpackage

// File: rtl/mips_debug_if.sv
// UART FIFO side of the debug controller.
//
// Handshake: rx side -- r_data is valid whenever rx_empty=0, and a cycle with
// rd=1 pops exactly that byte (rd is never high while rx_empty=1). tx side --
// a cycle with wr=1 pushes w_data (wr is never high while tx_full=1).
interface mips_debug_if;
  logic       rx_empty;
  logic [7:0] r_data;
  logic       rd;
  logic       tx_full;
  logic       wr;
  logic [7:0] w_data;

  // The debug controller pops rx bytes and pushes tx bytes
  modport master (input rx_empty, r_data, tx_full, output rd, wr, w_data);
  // The FIFO pair seen from the other side
  modport slave  (output rx_empty, r_data, tx_full, input rd, wr, w_data);
endinterface

// File: rtl/debug_frame_tx.sv
// Snapshot holder and byte serializer for one debug frame:
// 4 count bytes then the snapshot, both little-endian.
module debug_frame_tx #(
  parameter int DEBUG_W   = 322,
  parameter int NUM_BYTES = (DEBUG_W + 7) / 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               capture,
  input  logic               send,
  input  logic [31:0]        cycle_cnt,
  input  logic [DEBUG_W-1:0] debug_signal,
  input  logic               tx_full,
  output logic               wr,
  output logic [7:0]         w_data,
  output logic               done
);

  localparam int FRAME_LEN = 4 + NUM_BYTES;
  localparam int IDX_W     = $clog2(FRAME_LEN + 1);
  localparam int PAD_W     = 8 * NUM_BYTES;
  localparam int FRAME_W   = 8 * FRAME_LEN;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  logic [DEBUG_W-1:0] snapshot;
  logic [31:0]        cnt_snap;
  logic [IDX_W-1:0]   idx;
  logic [FRAME_W-1:0] frame;

  // Snapshot is zero-padded up to whole bytes so the top byte carries only
  // the remaining high bits of the debug bus.
  assign frame  = {PAD_W'(snapshot), cnt_snap};
  assign wr     = send && !tx_full;
  assign w_data = send ? frame[{idx, 3'b000} +: 8] : 8'h00;
  assign done   = wr && (idx == LAST_IDX);

  // Load the snapshot on capture, then advance the byte index on each push
  always_ff @(posedge clock) begin
    if (reset) begin
      snapshot <= '0;
      cnt_snap <= '0;
      idx      <= '0;
    end else if (capture) begin
      snapshot <= debug_signal;
      cnt_snap <= cycle_cnt;
      idx      <= '0;
    end else if (wr) begin
      idx <= idx + 1'b1;
    end
  end

endmodule

// File: rtl/mips_debug_unit.sv
// Host command FSM driving the MIPS core enable (run / step / halt / dump)
// plus the executed-cycle counter; frames are serialized by debug_frame_tx.
module mips_debug_unit
  import mips_debug_pkg::*;
#(
  parameter int DEBUG_W = 322
) (
  input  logic               clock,
  input  logic               reset,
  mips_debug_if.master       uart,
  input  logic [DEBUG_W-1:0] debug_signal,
  output logic               mips_enable,
  output logic               busy,
  output state_t             fsm_state
);

  localparam int NUM_BYTES = (DEBUG_W + 7) / 8;

  state_t      state;
  logic [31:0] cycle_cnt;
  logic        rx_take;
  logic        halt_cmd;
  logic        frame_done;

  // Bytes are only consumed while the FSM is listening (IDLE or RUN);
  // a halt byte disables the core in its own pop cycle.
  assign rx_take     = !uart.rx_empty && (state == ST_IDLE || state == ST_RUN);
  assign halt_cmd    = rx_take && (state == ST_RUN) && (uart.r_data == CMD_HALT);
  assign uart.rd     = rx_take;
  assign mips_enable = ((state == ST_RUN) && !halt_cmd) || (state == ST_STEP);
  assign busy        = (state != ST_IDLE);
  assign fsm_state   = state;

  // Executed-cycle counter, wraps naturally at 32 bits
  always_ff @(posedge clock) begin
    if (reset) cycle_cnt <= '0;
    else       cycle_cnt <= cycle_cnt + {31'b0, mips_enable};
  end

  // Command FSM
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!uart.rx_empty) begin
            case (uart.r_data)
              CMD_RUN:  state <= ST_RUN;
              CMD_STEP: state <= ST_STEP;
              CMD_DUMP: state <= ST_CAPTURE;
              default:  state <= ST_IDLE;
            endcase
          end
        end
        ST_RUN:     if (halt_cmd) state <= ST_CAPTURE;
        ST_STEP:    state <= ST_CAPTURE;
        ST_CAPTURE: state <= ST_SEND;
        ST_SEND:    if (frame_done) state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  debug_frame_tx #(
    .DEBUG_W   (DEBUG_W),
    .NUM_BYTES (NUM_BYTES)
  ) u_frame_tx (
    .clock        (clock),
    .reset        (reset),
    .capture      (state == ST_CAPTURE),
    .send         (state == ST_SEND),
    .cycle_cnt    (cycle_cnt),
    .debug_signal (debug_signal),
    .tx_full      (uart.tx_full),
    .wr           (uart.wr),
    .w_data       (uart.w_data),
    .done         (frame_done)
  );

endmodule

// File: tb/tb_mips_debug_unit.sv
// Bench for mips_debug_unit: emulated UART FIFOs, randomized core debug bus,
// expected frames built from the command timeline.
module tb_mips_debug_unit;
  import mips_debug_pkg::*;

  localparam int DW = 322;
  localparam int NB = (DW + 7) / 8;
  localparam int FL = 4 + NB;

  // ---------------- clock / reset ----------------
  logic          clock = 1'b0;
  logic          reset;
  logic [DW-1:0] debug_signal;
  logic          mips_enable;
  logic          busy;
  state_t        fsm_state;

  always #5 clock = ~clock;

  mips_debug_if bus();

  mips_debug_unit #(.DEBUG_W(DW)) u_dut (
    .clock        (clock),
    .reset        (reset),
    .uart         (bus),
    .debug_signal (debug_signal),
    .mips_enable  (mips_enable),
    .busy         (busy),
    .fsm_state    (fsm_state)
  );

  // ---------------- bench state ----------------
  int            checks   = 0;
  int            failures = 0;
  int            cyc      = 0;
  int            first_wr_cyc = -1;
  int            full_left = 0;
  bit            dbg_vary  = 1'b1;
  bit            throttle  = 1'b0;
  logic [31:0]   ref_cnt;
  logic [7:0]    rx_q[$];
  logic [7:0]    got_q[$];
  logic [7:0]    exp_q[$];
  logic [7:0]    ref_frame[$];
  logic [DW-1:0] dbg_hist[$];
  bit            en_hist[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_dbg();
    logic [DW-1:0] v = '0;
    for (int i = 0; i < (DW + 31) / 32; i++) v = {v[DW-33:0], 32'($urandom())};
    return v;
  endfunction

  function automatic int en_sum(input int a, input int b);
    int s = 0;
    for (int i = a; i < b; i++) s += int'(en_hist[i]);
    return s;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_rx();
    bus.rx_empty = (rx_q.size() == 0);
    bus.r_data   = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
  endtask

  // One clock: sample at the falling edge, update inputs 2 units after the rising edge
  task automatic cycle();
    bit popped;
    @(negedge clock);
    dbg_hist.push_back(debug_signal);
    en_hist.push_back(mips_enable);
    popped = bus.rd;
    if (bus.rd) check("rd_while_empty", 64'(bus.rx_empty), 64'd0);
    if (bus.wr) begin
      check("wr_while_full", 64'(bus.tx_full), 64'd0);
      if (got_q.size() == 0) first_wr_cyc = cyc;
      got_q.push_back(bus.w_data);
      if (throttle && (got_q.size() % 3 == 0)) full_left = 10;
    end
    @(posedge clock);
    #2;
    if (popped && rx_q.size() != 0) void'(rx_q.pop_front());
    cyc++;
    if (dbg_vary) debug_signal = rand_dbg();
    if (full_left > 0) begin
      bus.tx_full = 1'b1;
      full_left--;
    end else begin
      bus.tx_full = 1'b0;
    end
    drive_rx();
  endtask

  task automatic push(input logic [7:0] b);
    rx_q.push_back(b);
    drive_rx();
  endtask

  task automatic new_frame();
    got_q.delete();
    first_wr_cyc = -1;
  endtask

  task automatic wait_frame(input int budget);
    for (int i = 0; i < budget && got_q.size() < FL; i++) cycle();
    check("frame_len", 64'(got_q.size()), 64'(FL));
  endtask

  // ---------------- scoreboard ----------------
  task automatic build_exp(input logic [31:0] cnt, input logic [DW-1:0] snap);
    logic [DW-1:0] s;
    exp_q.delete();
    for (int k = 0; k < 4; k++) exp_q.push_back(8'((cnt >> (8 * k)) & 32'hFF));
    s = snap;
    for (int k = 0; k < NB; k++) begin
      exp_q.push_back(s[7:0]);
      s = s >> 8;
    end
  endtask

  task automatic check_frame(input string tag, input logic [31:0] cnt, input logic [DW-1:0] snap);
    logic [7:0] g;
    build_exp(cnt, snap);
    for (int k = 0; k < FL; k++) begin
      g = (k < got_q.size()) ? got_q[k] : 8'h00;
      check($sformatf("%s_byte%0d", tag, k), 64'(g), 64'(exp_q[k]));
    end
  endtask

  task automatic check_idle(input string tag);
    #1;
    check({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int t, t0, t1, n, hold;
    logic [7:0] junk_tbl[4];
    logic [DW-1:0] dump_val;
    junk_tbl[0] = CMD_STEP; junk_tbl[1] = CMD_DUMP;
    junk_tbl[2] = CMD_RUN;  junk_tbl[3] = 8'h41;

    reset = 1'b1;
    debug_signal = rand_dbg();
    bus.tx_full = 1'b0;
    drive_rx();
    repeat (3) cycle();
    reset = 1'b0;
    ref_cnt = '0;
    #1;
    check("rst_rd", 64'(bus.rd), 64'd0);
    check("rst_wr", 64'(bus.wr), 64'd0);
    check("rst_wdata", 64'(bus.w_data), 64'd0);
    check("rst_enable", 64'(mips_enable), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_state", 64'(fsm_state), 64'(ST_IDLE));

    // Single step: one enable pulse, capture one cycle after it
    new_frame();
    t = cyc;
    push(CMD_STEP);
    wait_frame(200);
    ref_cnt = ref_cnt + 32'd1;
    check("step_pulse", 64'(en_hist[t+1]), 64'd1);
    check("step_en_total", 64'(en_sum(t, cyc)), 64'd1);
    check("step_first_wr", 64'(first_wr_cyc), 64'(t + 3));
    check("step_burst", 64'(cyc - 1 - first_wr_cyc), 64'(FL - 1));
    check_frame("step", ref_cnt, dbg_hist[t+2]);
    check_idle("step");

    // Run / halt: once for 100 cycles, once for a random length with a stray byte
    for (int r = 0; r < 2; r++) begin
      n = (r == 0) ? 100 : int'($urandom_range(30, 150));
      new_frame();
      t0 = cyc;
      push(CMD_RUN);
      cycle();
      for (int i = 0; i < n; i++) begin
        if (r == 1 && i == n / 2) push(junk_tbl[$urandom_range(0, 3)]);
        cycle();
      end
      t1 = cyc;
      push(CMD_HALT);
      wait_frame(200);
      ref_cnt = ref_cnt + 32'(n);
      check($sformatf("run%0d_en_total", r), 64'(en_sum(t0, cyc)), 64'(n));
      check($sformatf("run%0d_halt_cycle_en", r), 64'(en_hist[t1]), 64'd0);
      check_frame($sformatf("run%0d", r), ref_cnt, dbg_hist[t1+1]);
      check_idle($sformatf("run%0d", r));
    end

    // Dump with a quiet core, then the same dump under backpressure
    dbg_vary = 1'b0;
    dump_val = rand_dbg();
    debug_signal = dump_val;
    new_frame();
    push(CMD_DUMP);
    wait_frame(200);
    check_frame("dump", ref_cnt, dump_val);
    ref_frame = got_q;
    check_idle("dump");

    new_frame();
    throttle = 1'b1;
    push(CMD_DUMP);
    wait_frame(1000);
    throttle = 1'b0;
    full_left = 0;
    bus.tx_full = 1'b0;
    check_frame("dump_bp", ref_cnt, dump_val);
    for (int k = 0; k < FL; k++)
      check($sformatf("dump_bp_same%0d", k), 64'((k < got_q.size()) ? got_q[k] : 8'h00),
            64'(ref_frame[k]));
    repeat (2) cycle();

    // Unknown byte and halt in IDLE are discarded; only one frame follows
    new_frame();
    push(8'h41);
    push(CMD_HALT);
    push(CMD_DUMP);
    wait_frame(200);
    check_frame("junk", ref_cnt, dump_val);
    repeat (60) cycle();
    check("junk_one_frame", 64'(got_q.size()), 64'(FL));
    check("junk_rx_drained", 64'(rx_q.size()), 64'd0);

    // Counter wrap: preload all ones, then step
    dbg_vary = 1'b1;
    force u_dut.cycle_cnt = 32'hFFFF_FFFF;
    repeat (2) cycle();
    release u_dut.cycle_cnt;
    ref_cnt = 32'hFFFF_FFFF;
    new_frame();
    t = cyc;
    push(CMD_STEP);
    wait_frame(200);
    ref_cnt = ref_cnt + 32'd1;
    check_frame("wrap", ref_cnt, dbg_hist[t+2]);
    check_idle("wrap");

    // Reset while byte 20 of a frame is on the bus
    new_frame();
    push(CMD_DUMP);
    for (int i = 0; i < 200 && got_q.size() < 20; i++) cycle();
    check("mid_reached", 64'(got_q.size()), 64'd20);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    ref_cnt = '0;
    hold = got_q.size();
    #1;
    check("mid_rst_wr", 64'(bus.wr), 64'd0);
    check("mid_rst_wdata", 64'(bus.w_data), 64'd0);
    check("mid_rst_enable", 64'(mips_enable), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    repeat (60) cycle();
    check("mid_aborted", 64'(got_q.size()), 64'(hold));

    dbg_vary = 1'b0;
    dump_val = rand_dbg();
    debug_signal = dump_val;
    new_frame();
    push(CMD_DUMP);
    wait_frame(200);
    check_frame("post_rst", ref_cnt, dump_val);
    check_idle("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_debug_unit.md
# mips_debug_unit

Debug controller sitting between the UART byte FIFOs and the five-stage MIPS_DLX pipeline. It drives the pipeline `enable` to run, single-step or halt the core on host command. It snapshots the core's 322-bit pipeline-latch debug bus and a 32-bit executed-cycle counter, and streams the snapshot back to the host as a fixed-length byte frame.

## Interface
Parameters:
- `DEBUG_W`, 322: width of the core debug bus.
- `NUM_BYTES`, derived `(DEBUG_W+7)/8` = 41: snapshot bytes per frame.

Ports:
- `clock  in  1` — single system clock; all logic rising-edge.
- `reset  in  1` — synchronous, active-high.
- `rx_empty  in  1` — UART receive FIFO empty flag.
- `r_data  in  8` — head byte of the receive FIFO, valid while `rx_empty`=0.
- `rd  out  1` — one-cycle pop of the receive FIFO.
- `tx_full  in  1` — UART transmit FIFO full flag.
- `wr  out  1` — one-cycle push into the transmit FIFO.
- `w_data  out  8` — byte pushed when `wr`=1.
- `debug_signal  in  DEBUG_W` — core pipeline-latch debug bus.
- `mips_enable  out  1` — drives the core `enable`.
- `busy  out  1` — high in any state except IDLE.

## Operation
- Commands are single ASCII bytes:
  - `c` (0x63): run.
  - `s` (0x73): step.
  - `h` (0x68): halt.
  - `d` (0x64): dump.
- All other bytes are popped and discarded.
- States: IDLE, RUN, STEP, CAPTURE, SEND.
- IDLE:
  - If `rx_empty`=0: `rd`=1 and `r_data` is decoded the same cycle.
  - `c` → RUN; `s` → STEP; `d` → CAPTURE.
  - `h` or unknown byte → stay in IDLE.
- RUN:
  - `mips_enable`=1 every cycle.
  - If `rx_empty`=0: `rd`=1.
  - If the byte is `h`: `mips_enable`=0 in that same cycle, next state CAPTURE.
  - Any other byte is discarded and the core keeps running.
- STEP: `mips_enable`=1 for exactly one cycle → CAPTURE.
- CAPTURE:
  - `snapshot <= debug_signal`, `cnt_snap <= cycle_cnt`, `idx <= 0`.
  - Next state SEND.
- SEND:
  - `wr`=1 whenever `tx_full`=0; `idx` increments on each `wr`.
  - After the final byte (`idx` = `NUM_BYTES`+3), next state IDLE.
  - `rd` is held at 0 throughout.
- Frame: 4+`NUM_BYTES` = 45 bytes, sent in this order:
  - `cnt_snap` little-endian (bytes 0–3).
  - Snapshot byte k = `snapshot[8k+7:8k]`, k = 0..40, little-endian.
  - Byte 40 carries bits 321:320 in [1:0]; its bits [7:2] are 0.
- `cycle_cnt` is 32 bits:
  - Increments in every cycle with `mips_enable`=1.
  - Wraps 0xFFFFFFFF → 0.
  - Cleared only by reset.
- Only `mips_enable` controls the core; the core is never stalled mid-frame because it is disabled outside RUN/STEP.

## Timing
- Reset values:
  - `rd`=0, `wr`=0, `w_data`=0x00, `mips_enable`=0, `busy`=0.
  - State IDLE, `cycle_cnt`=0, `idx`=0, snapshot=0.
- `rd`, `wr`, `w_data` and `mips_enable` are combinational from state and FIFO flags. `wr` is never asserted while `tx_full`=1.
- Step latency:
  - Pop of `s` at cycle t.
  - Enable pulse at t+1.
  - Capture at t+2; the capture reflects latches updated at the t+1 edge.
  - First `wr` at t+3 if `tx_full`=0.
- Frame length without backpressure: 45 consecutive `wr` cycles. Backpressure inserts idle cycles; no byte is dropped or duplicated.
- Halt: the `h`-pop cycle has `mips_enable`=0, so the cycles counted equal the RUN cycles before that pop.
- `rx_empty` deasserting in the same cycle as a state change is sampled only in IDLE/RUN.
- Reset mid-SEND or mid-RUN:
  - Frame aborted.
  - All outputs at reset values in the cycle after reset is sampled.
  - `cycle_cnt` cleared.

## Structure
- Package `mips_debug_pkg`:
  - Command constants `CMD_RUN`, `CMD_STEP`, `CMD_HALT`, `CMD_DUMP`.
  - State enum.
  - Frame-length constant `FRAME_BYTES`.
- Sub-module `debug_frame_tx`:
  - Holds the snapshot and `cnt_snap` registers.
  - Provides byte selection by `idx`, the `wr`/`tx_full` handshake and `done`.
- The top-level module holds the command FSM and `cycle_cnt`.

## Test plan
- Reset, then push `s`:
  - `mips_enable` high exactly one cycle.
  - 45 bytes out.
  - Bytes 0–3 = 01 00 00 00.
  - Bytes 4–44 match `debug_signal` sampled one cycle after the pulse.
- Push `c`, wait 100 cycles, push `h`:
  - Enable high for exactly the cycles between the two pops.
  - Frame count field equals that number.
  - `busy` low after the last byte.
- Assert `tx_full` for 10 cycles every 3rd byte during a `d` dump:
  - No `wr` while full.
  - The 45-byte sequence is identical to the unthrottled dump.
- Push 0x41, 0x68, then `d` in IDLE:
  - First two bytes are popped and ignored.
  - Only one frame is produced, with count unchanged.
- Preload `cycle_cnt` 0xFFFFFFFF (force), then step: count field = 00 00 00 00.
- Assert reset at byte 20 of a frame:
  - `wr`=0 from the next cycle on.
  - `cycle_cnt`=0.
  - A subsequent `d` yields count 00 00 00 00.
